// File: rtl/battle_if.sv
// Bundle of control, team-load and result signals between the shop/control
// FSM (master) and the battle engine (slave).
interface battle_if #(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned STAT_W    = 4,
  parameter int unsigned COIN_W    = 10,
  parameter int unsigned LIVES_W   = 2,
  parameter int unsigned IDX_W     = 1
);
  logic                          start;
  logic                          new_game;
  logic [NUM_SLOTS*STAT_W-1:0]   player_atk;
  logic [NUM_SLOTS*STAT_W-1:0]   player_hp;
  logic [NUM_SLOTS*STAT_W-1:0]   opp_atk;
  logic [NUM_SLOTS*STAT_W-1:0]   opp_hp;
  logic [NUM_SLOTS-1:0]          player_valid;
  logic [NUM_SLOTS-1:0]          opp_valid;
  logic                          busy;
  logic                          done;
  logic                          win;
  logic                          tie;
  logic [IDX_W-1:0]              front_p;
  logic [IDX_W-1:0]              front_o;
  logic [NUM_SLOTS*STAT_W-1:0]   p_hp_now;
  logic [NUM_SLOTS*STAT_W-1:0]   o_hp_now;
  logic [LIVES_W-1:0]            lives;
  logic [7:0]                    round;
  logic [COIN_W-1:0]             coins;
  logic                          alive;

  modport master (
    output start, new_game, player_atk, player_hp, opp_atk, opp_hp, player_valid, opp_valid,
    input  busy, done, win, tie, front_p, front_o, p_hp_now, o_hp_now, lives, round, coins,
           alive
  );

  modport slave (
    input  start, new_game, player_atk, player_hp, opp_atk, opp_hp, player_valid, opp_valid,
    output busy, done, win, tie, front_p, front_o, p_hp_now, o_hp_now, lives, round, coins,
           alive
  );
endinterface

// File: rtl/battle_engine.sv
// Paced auto-battle engine: front pets of each team strike simultaneously
// every STRIKE_CYC+2 cycles until a team runs out of live pets, then the
// run-level lives/round/coins counters are updated and a result is published.
module battle_engine #(
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned STAT_W      = 4,
  parameter int unsigned STRIKE_CYC  = 1,
  parameter int unsigned COIN_W      = 10,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned START_COINS = 10,
  parameter int unsigned WIN_REWARD  = 3,
  parameter int unsigned LOSE_REWARD = 1
) (
  input logic     clk,
  input logic     reset_n,
  battle_if.slave bus
);

  localparam int unsigned LIVES_W = $clog2(START_LIVES + 1);
  localparam int unsigned IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned VEC_W   = NUM_SLOTS * STAT_W;
  localparam int unsigned CNT_W   = (STRIKE_CYC > 1) ? $clog2(STRIKE_CYC) : 1;
  localparam logic [CNT_W-1:0] CntReload = CNT_W'(STRIKE_CYC - 1);

  typedef enum logic [2:0] {StIdle, StWait, StStrike, StAdvance, StEnd} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   p_atk_q, p_atk_d, o_atk_q, o_atk_d;
  logic [VEC_W-1:0]   p_hp_q, p_hp_d, o_hp_q, o_hp_d;
  logic [IDX_W-1:0]   front_p_q, front_p_d, front_o_q, front_o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               win_q, win_d;
  logic               tie_q, tie_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [7:0]         round_q, round_d;
  logic [COIN_W-1:0]  coins_q, coins_d;

  logic               alive;
  logic               accept;
  logic [VEC_W-1:0]   p_hp_load, o_hp_load;
  logic               load_p_empty, load_o_empty;
  logic               p_empty, o_empty;
  logic [STAT_W-1:0]  p_cur_hp, p_cur_atk, o_cur_hp, o_cur_atk;
  logic [STAT_W-1:0]  p_new_hp, o_new_hp;
  logic [COIN_W:0]    coin_sum;

  // Lowest live slot; dflt is kept when the team has no live pet.
  function automatic logic [IDX_W-1:0] front_of(input logic [VEC_W-1:0] hp,
                                                input logic [IDX_W-1:0] dflt);
    logic [IDX_W-1:0] idx;
    idx = dflt;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hp[i*STAT_W +: STAT_W] != '0) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic any_live(input logic [VEC_W-1:0] hp);
    logic live;
    live = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hp[i*STAT_W +: STAT_W] != '0) live = 1'b1;
    end
    return live;
  endfunction

  assign alive  = (lives_q != '0);
  assign accept = (state_q == StIdle) && bus.start && !bus.new_game && alive;

  // Load-time health with unoccupied slots forced to zero so they never count as live.
  always_comb begin
    p_hp_load = '0;
    o_hp_load = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.player_valid[i]) p_hp_load[i*STAT_W +: STAT_W] = bus.player_hp[i*STAT_W +: STAT_W];
      if (bus.opp_valid[i])    o_hp_load[i*STAT_W +: STAT_W] = bus.opp_hp[i*STAT_W +: STAT_W];
    end
    load_p_empty = !any_live(p_hp_load);
    load_o_empty = !any_live(o_hp_load);
    p_empty      = !any_live(p_hp_q);
    o_empty      = !any_live(o_hp_q);
  end

  // Select the two front pets and compute their saturated post-strike health.
  always_comb begin
    p_cur_hp  = '0;
    p_cur_atk = '0;
    o_cur_hp  = '0;
    o_cur_atk = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (front_p_q == IDX_W'(i)) begin
        p_cur_hp  = p_hp_q[i*STAT_W +: STAT_W];
        p_cur_atk = p_atk_q[i*STAT_W +: STAT_W];
      end
      if (front_o_q == IDX_W'(i)) begin
        o_cur_hp  = o_hp_q[i*STAT_W +: STAT_W];
        o_cur_atk = o_atk_q[i*STAT_W +: STAT_W];
      end
    end
    p_new_hp = (p_cur_hp > o_cur_atk) ? (p_cur_hp - o_cur_atk) : '0;
    o_new_hp = (o_cur_hp > p_cur_atk) ? (o_cur_hp - p_cur_atk) : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (load_p_empty || load_o_empty) ? StEnd : StWait;
      end
      StWait:    if (cnt_q == '0) state_d = StStrike;
      StStrike:  state_d = StAdvance;
      StAdvance: state_d = (p_empty || o_empty) ? StEnd : StWait;
      StEnd:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM datapath and output next-state values.
  always_comb begin
    cnt_d     = cnt_q;
    p_atk_d   = p_atk_q;
    o_atk_d   = o_atk_q;
    p_hp_d    = p_hp_q;
    o_hp_d    = o_hp_q;
    front_p_d = front_p_q;
    front_o_d = front_o_q;
    done_d    = 1'b0;
    win_d     = win_q;
    tie_d     = tie_q;
    lives_d   = lives_q;
    round_d   = round_q;
    coins_d   = coins_q;
    coin_sum  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.new_game) begin
          lives_d = LIVES_W'(START_LIVES);
          round_d = 8'd1;
          coins_d = COIN_W'(START_COINS);
        end else if (accept) begin
          p_atk_d   = bus.player_atk;
          o_atk_d   = bus.opp_atk;
          p_hp_d    = p_hp_load;
          o_hp_d    = o_hp_load;
          front_p_d = front_of(p_hp_load, '0);
          front_o_d = front_of(o_hp_load, '0);
          win_d     = 1'b0;
          tie_d     = 1'b0;
          cnt_d     = CntReload;
        end
      end
      StWait: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      StStrike: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (front_p_q == IDX_W'(i)) p_hp_d[i*STAT_W +: STAT_W] = p_new_hp;
          if (front_o_q == IDX_W'(i)) o_hp_d[i*STAT_W +: STAT_W] = o_new_hp;
        end
      end
      StAdvance: begin
        // An emptied team keeps its last front so the display does not jump.
        front_p_d = front_of(p_hp_q, front_p_q);
        front_o_d = front_of(o_hp_q, front_o_q);
        cnt_d     = CntReload;
      end
      StEnd: begin
        done_d = 1'b1;
        tie_d  = p_empty && o_empty;
        win_d  = o_empty && !p_empty;
        if (p_empty && !o_empty && (lives_q != '0)) lives_d = lives_q - LIVES_W'(1);
        coin_sum = {1'b0, coins_q} +
                   ((o_empty && !p_empty) ? (COIN_W+1)'(WIN_REWARD) : (COIN_W+1)'(LOSE_REWARD));
        coins_d  = coin_sum[COIN_W] ? '1 : coin_sum[COIN_W-1:0];
        if (round_q != 8'hFF) round_d = round_q + 8'd1;
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      p_atk_q   <= '0;
      o_atk_q   <= '0;
      p_hp_q    <= '0;
      o_hp_q    <= '0;
      front_p_q <= '0;
      front_o_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      tie_q     <= 1'b0;
      lives_q   <= LIVES_W'(START_LIVES);
      round_q   <= 8'd1;
      coins_q   <= COIN_W'(START_COINS);
    end else begin
      cnt_q     <= cnt_d;
      p_atk_q   <= p_atk_d;
      o_atk_q   <= o_atk_d;
      p_hp_q    <= p_hp_d;
      o_hp_q    <= o_hp_d;
      front_p_q <= front_p_d;
      front_o_q <= front_o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      win_q     <= win_d;
      tie_q     <= tie_d;
      lives_q   <= lives_d;
      round_q   <= round_d;
      coins_q   <= coins_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.win      = win_q;
  assign bus.tie      = tie_q;
  assign bus.front_p  = front_p_q;
  assign bus.front_o  = front_o_q;
  assign bus.p_hp_now = p_hp_q;
  assign bus.o_hp_now = o_hp_q;
  assign bus.lives    = lives_q;
  assign bus.round    = round_q;
  assign bus.coins    = coins_q;
  assign bus.alive    = alive;

endmodule

// File: tb/tb_battle_engine.sv
// Bench for battle_engine: table-driven battles checked through a result
// scoreboard, plus hand sequences for lives, new_game, back-to-back start,
// pacing and mid-battle reset.
module tb_battle_engine;
  localparam int unsigned NS = 2;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned LW = 2;
  localparam int unsigned IW = 1;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  battle_if #(.NUM_SLOTS(NS), .STAT_W(SW), .COIN_W(CW), .LIVES_W(LW), .IDX_W(IW)) bus ();
  battle_if #(.NUM_SLOTS(NS), .STAT_W(SW), .COIN_W(CW), .LIVES_W(LW), .IDX_W(IW)) bus4 ();

  battle_engine #(.NUM_SLOTS(NS), .STAT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  battle_engine #(.NUM_SLOTS(NS), .STAT_W(SW), .STRIKE_CYC(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  // The paced engine shares team data with the main one; only start/new_game are separate.
  assign bus4.player_atk   = bus.player_atk;
  assign bus4.player_hp    = bus.player_hp;
  assign bus4.opp_atk      = bus.opp_atk;
  assign bus4.opp_hp       = bus.opp_hp;
  assign bus4.player_valid = bus.player_valid;
  assign bus4.opp_valid    = bus.opp_valid;

  typedef struct {
    logic [7:0] p_atk, p_hp, o_atk, o_hp;
    logic [1:0] pv, ov;
    logic       win, tie;
    int         lat;
    logic [7:0] php, ohp;
    logic       fp0, fo0, fp, fo;
  } vec_t;

  typedef struct {
    int         done_at;
    logic       win, tie;
    int         lives, round, coins;
    logic [7:0] php, ohp;
    logic       fp, fo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_lives = 3;
  int   m_round = 1;
  int   m_coins = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p_atk, p_hp, o_atk, o_hp, input logic [1:0] pv,
                              ov, input logic win, tie, input int lat, input logic [7:0] php,
                              ohp, input logic fp0, fo0, fp, fo);
    vec_t v;
    v.p_atk = p_atk; v.p_hp = p_hp; v.o_atk = o_atk; v.o_hp = o_hp;
    v.pv = pv; v.ov = ov; v.win = win; v.tie = tie; v.lat = lat;
    v.php = php; v.ohp = ohp; v.fp0 = fp0; v.fo0 = fo0; v.fp = fp; v.fo = fo;
    return v;
  endfunction

  // Run-level bookkeeping model: advanced once per battle when it is queued.
  task automatic push_expect(input vec_t v, input int accept_edge);
    exp_t e;
    if (!v.win && !v.tie && m_lives > 0) m_lives--;
    m_coins = m_coins + (v.win ? 3 : 1);
    if (m_coins > 1023) m_coins = 1023;
    if (m_round < 255) m_round++;
    e.done_at = accept_edge + v.lat;
    e.win = v.win; e.tie = v.tie;
    e.lives = m_lives; e.round = m_round; e.coins = m_coins;
    e.php = v.php; e.ohp = v.ohp; e.fp = v.fp; e.fo = v.fo;
    sb.push_back(e);
  endtask

  task automatic set_team(input vec_t v);
    bus.player_atk = v.p_atk; bus.player_hp = v.p_hp;
    bus.opp_atk = v.o_atk; bus.opp_hp = v.o_hp;
    bus.player_valid = v.pv; bus.opp_valid = v.ov;
  endtask

  // Call at a negedge: raise start and queue the expected result.
  task automatic drive_vec(input vec_t v);
    set_team(v);
    bus.start = 1'b1;
    push_expect(v, cyc + 1);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    @(negedge clk);
    bus.start = 1'b0;
    check("front_p_load", 32'(bus.front_p), 32'(v.fp0));
    check("front_o_load", 32'(bus.front_o), 32'(v.fo0));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("done_edge", 32'(cyc), 32'(mon_e.done_at));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("win", 32'(bus.win), 32'(mon_e.win));
        check("tie", 32'(bus.tie), 32'(mon_e.tie));
        check("lives", 32'(bus.lives), 32'(mon_e.lives));
        check("round", 32'(bus.round), 32'(mon_e.round));
        check("coins", 32'(bus.coins), 32'(mon_e.coins));
        check("p_hp_now", 32'(bus.p_hp_now), 32'(mon_e.php));
        check("o_hp_now", 32'(bus.o_hp_now), 32'(mon_e.ohp));
        check("front_p_end", 32'(bus.front_p), 32'(mon_e.fp));
        check("front_o_end", 32'(bus.front_o), 32'(mon_e.fo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t lose;
    int   n;
    int   acc;
    logic seen;

    //               p_atk  p_hp   o_atk  o_hp   pv     ov     win   tie  lat php    ohp   fp0 fo0 fp fo
    vecs[0] = mk(8'h03, 8'h05, 8'h02, 8'h03, 2'b01, 2'b01, 1'b1, 1'b0, 4, 8'h03, 8'h00, 0, 0, 0, 0);
    vecs[1] = mk(8'h0F, 8'h02, 8'h09, 8'h03, 2'b01, 2'b01, 1'b0, 1'b1, 4, 8'h00, 8'h00, 0, 0, 0, 0);
    vecs[2] = mk(8'h11, 8'h91, 8'h25, 8'h27, 2'b11, 2'b10, 1'b1, 1'b0, 7, 8'h70, 8'h00, 0, 1, 1, 1);
    vecs[3] = mk(8'h32, 8'h43, 8'h21, 8'h54, 2'b11, 2'b11, 1'b1, 1'b0, 13, 8'h20, 8'h00, 0, 0, 1, 1);
    vecs[4] = mk(8'h01, 8'h01, 8'h05, 8'h05, 2'b01, 2'b01, 1'b0, 1'b0, 4, 8'h00, 8'h04, 0, 0, 0, 0);
    vecs[5] = mk(8'h11, 8'h55, 8'h02, 8'h93, 2'b00, 2'b01, 1'b0, 1'b0, 1, 8'h00, 8'h03, 0, 0, 0, 0);
    lose = vecs[4];

    reset_n = 1'b0;
    bus.start = 1'b0; bus.new_game = 1'b0;
    bus4.start = 1'b0; bus4.new_game = 1'b0;
    set_team(vecs[0]);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_win", 32'(bus.win), 32'd0);
    check("rst_tie", 32'(bus.tie), 32'd0);
    check("rst_front_p", 32'(bus.front_p), 32'd0);
    check("rst_front_o", 32'(bus.front_o), 32'd0);
    check("rst_p_hp", 32'(bus.p_hp_now), 32'd0);
    check("rst_o_hp", 32'(bus.o_hp_now), 32'd0);
    check("rst_lives", 32'(bus.lives), 32'd3);
    check("rst_round", 32'(bus.round), 32'd1);
    check("rst_coins", 32'(bus.coins), 32'd10);
    check("rst_alive", 32'(bus.alive), 32'd1);
    reset_n = 1'b1;

    // Table of battles.
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      drain(60);
    end

    // Third loss exhausts lives; start is then ignored.
    apply(lose);
    drain(60);
    check("exhaust_lives", 32'(bus.lives), 32'd0);
    check("exhaust_alive", 32'(bus.alive), 32'd0);
    @(negedge clk);
    set_team(vecs[0]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("dead_start_busy", 32'(bus.busy), 32'd0);
    repeat (6) @(negedge clk);
    check("dead_start_busy_late", 32'(bus.busy), 32'd0);

    // new_game restores the run counters.
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    check("ng_lives", 32'(bus.lives), 32'd3);
    check("ng_round", 32'(bus.round), 32'd1);
    check("ng_coins", 32'(bus.coins), 32'd10);
    check("ng_alive", 32'(bus.alive), 32'd1);
    m_lives = 3; m_round = 1; m_coins = 10;

    // new_game wins over a simultaneous start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.new_game = 1'b0;
    check("ng_prio_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    check("ng_prio_round", 32'(bus.round), 32'd1);

    // Start reasserted in the done cycle is accepted.
    apply(vecs[0]);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check("b2b_done_seen", 32'(seen), 32'd1);
    drive_vec(vecs[1]);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done_low", 32'(bus.done), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_win_cleared", 32'(bus.win), 32'd0);
    drain(60);

    // Pacing: STRIKE_CYC=4 one-strike battle finishes 7 edges after accept.
    @(negedge clk);
    set_team(vecs[0]);
    bus4.start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    bus4.start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      if (bus4.done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("pace_done_seen", 32'(seen), 32'd1);
    check("pace_done_edge", 32'(cyc - acc), 32'd7);
    check("pace_win", 32'(bus4.win), 32'd1);
    check("pace_coins", 32'(bus4.coins), 32'd13);
    check("pace_p_hp", 32'(bus4.p_hp_now), 32'h03);

    // Reset in the middle of WAIT aborts with no done pulse.
    @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    check("mid_busy_before", 32'(bus4.busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    m_lives = 3; m_round = 1; m_coins = 10;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_win", 32'(bus4.win), 32'd0);
    check("mid_rst_lives", 32'(bus4.lives), 32'd3);
    check("mid_rst_round", 32'(bus4.round), 32'd1);
    check("mid_rst_coins", 32'(bus4.coins), 32'd10);
    check("mid_rst_p_hp", 32'(bus4.p_hp_now), 32'd0);
    check("mid_rst_o_hp", 32'(bus4.o_hp_now), 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    check("mid_rst_round_after", 32'(bus4.round), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
